// File: rtl/truth_table_sweeper.sv
// Drives all 16 {a,b,c,d} vectors into a 4-input circuit, captures s1 into a truth table and
// compares it against EXPECTED. Optional FIRST_FAIL_EN macro adds first-mismatch reporting.
module truth_table_sweeper #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED      = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        s1,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] table_out,
`ifdef FIRST_FAIL_EN
  output logic        first_fail_valid,
  output logic [3:0]  first_fail_idx,
`endif
  output logic [4:0]  mismatch_count
);

  // state | meaning
  // IDLE  | waiting for start after reset, outputs all zero
  // SWEEP | stepping through vectors 0..15, sampling s1 per vector
  // DONE  | sweep complete, table/count/pass held until restart
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  localparam int             CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(SETTLE_CYCLES - 1);

  state_t        state;
  logic [3:0]    index;
  logic [CW-1:0] cnt;
  logic          miss;
  logic [4:0]    mm_next;

  assign {a, b, c, d} = index;
  assign miss         = (s1 != EXPECTED[index]);
  assign mm_next      = mismatch_count + 5'(miss);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      index            <= 4'd0;
      cnt              <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      table_out        <= 16'h0000;
      mismatch_count   <= 5'd0;
`ifdef FIRST_FAIL_EN
      first_fail_valid <= 1'b0;
      first_fail_idx   <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= SWEEP;
            index            <= 4'd0;
            cnt              <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            table_out        <= 16'h0000;
            mismatch_count   <= 5'd0;
`ifdef FIRST_FAIL_EN
            first_fail_valid <= 1'b0;
            first_fail_idx   <= 4'd0;
`endif
          end
        end
        SWEEP: begin
          if (cnt == CNT_LAST) begin
            cnt              <= '0;
            table_out[index] <= s1;
            mismatch_count   <= mm_next;
`ifdef FIRST_FAIL_EN
            if (miss && !first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_idx   <= index;
            end
`endif
            // index wraps to 0 on the last vector so the circuit inputs park at 0000
            index <= index + 4'd1;
            if (index == 4'd15) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (mm_next == 5'd0);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: four instances with different EXPECTED masks share one stimulus
// stream; every cycle of every sweep is compared against an arithmetic model of the sweep.
module tb_truth_table_sweeper;

  localparam int S = 2;
  localparam int SWEEP_LEN = 16 * S;
  localparam logic [15:0] EXP_TAB [4] = '{16'h0000, 16'hFF00, 16'h8888, 16'hFF01};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] tt_cur = 16'h0000;

  logic        a_w [4];
  logic        b_w [4];
  logic        c_w [4];
  logic        d_w [4];
  logic        s1_w [4];
  logic        busy_w [4];
  logic        done_w [4];
  logic        pass_w [4];
  logic [15:0] table_w [4];
  logic [4:0]  mm_w [4];
`ifdef FIRST_FAIL_EN
  logic        ffv_w [4];
  logic [3:0]  ffi_w [4];
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    // circuit under test is modelled as a lookup into the current truth table
    assign s1_w[g] = tt_cur[{a_w[g], b_w[g], c_w[g], d_w[g]}];

    truth_table_sweeper #(.SETTLE_CYCLES(S), .EXPECTED(EXP_TAB[g])) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .a              (a_w[g]),
      .b              (b_w[g]),
      .c              (c_w[g]),
      .d              (d_w[g]),
      .s1             (s1_w[g]),
      .busy           (busy_w[g]),
      .done           (done_w[g]),
      .pass           (pass_w[g]),
      .table_out      (table_w[g]),
`ifdef FIRST_FAIL_EN
      .first_fail_valid (ffv_w[g]),
      .first_fail_idx   (ffi_w[g]),
`endif
      .mismatch_count (mm_w[g])
    );
  end

  task automatic chk(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, g, obs, exp);
    end
  endtask

  task automatic check_zero();
    for (int g = 0; g < 4; g++) begin
      chk("abcd_rst", g, 32'({a_w[g], b_w[g], c_w[g], d_w[g]}), 32'd0);
      chk("busy_rst", g, 32'(busy_w[g]), 32'd0);
      chk("done_rst", g, 32'(done_w[g]), 32'd0);
      chk("pass_rst", g, 32'(pass_w[g]), 32'd0);
      chk("table_rst", g, 32'(table_w[g]), 32'd0);
      chk("mm_rst", g, 32'(mm_w[g]), 32'd0);
`ifdef FIRST_FAIL_EN
      chk("ffv_rst", g, 32'(ffv_w[g]), 32'd0);
      chk("ffi_rst", g, 32'(ffi_w[g]), 32'd0);
`endif
    end
  endtask

  // j = number of clock edges since the edge that sampled start
  task automatic check_sweep(input int j);
    int          n;
    logic [15:0] mask;
    logic [15:0] diff;
    int          mm_e;
    int          idx_e;
    bit          done_e;
    int          ff_idx;
    n      = (j >= SWEEP_LEN) ? 16 : j / S;
    done_e = (j >= SWEEP_LEN);
    idx_e  = done_e ? 0 : j / S;
    mask   = 16'h0000;
    for (int i = 0; i < n; i++) mask[i] = 1'b1;
    for (int g = 0; g < 4; g++) begin
      diff = (tt_cur ^ EXP_TAB[g]) & mask;
      mm_e = $countones(diff);
      ff_idx = 0;
      for (int i = 15; i >= 0; i--) if (diff[i]) ff_idx = i;
      chk("abcd", g, 32'({a_w[g], b_w[g], c_w[g], d_w[g]}), 32'(idx_e));
      chk("busy", g, 32'(busy_w[g]), 32'(!done_e));
      chk("done", g, 32'(done_w[g]), 32'(done_e));
      chk("pass", g, 32'(pass_w[g]), 32'(done_e && mm_e == 0));
      chk("table", g, 32'(table_w[g]), 32'(tt_cur & mask));
      chk("mm", g, 32'(mm_w[g]), 32'(mm_e));
`ifdef FIRST_FAIL_EN
      chk("ffv", g, 32'(ffv_w[g]), 32'(diff != 16'h0000));
      chk("ffi", g, 32'(ffi_w[g]), 32'(ff_idx));
`endif
    end
  endtask

  // abort_at > 0: assert rst in place of that edge and stop the sweep there
  task automatic run_sweep(input logic [15:0] tt, input bit hold, input int abort_at);
    tt_cur = tt;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    check_sweep(0);
    for (int j = 1; j <= SWEEP_LEN; j++) begin
      if (j == abort_at) begin
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero();
        return;
      end
      @(posedge clk); #1;
      check_sweep(j);
    end
    start = 1'b0;
  endtask

  task automatic idle_done(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      check_sweep(SWEEP_LEN);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero();
    rst = 1'b0;
    @(posedge clk); #1;
    check_zero();

    run_sweep(16'h0000, 1'b0, 0);
    idle_done(2);
    run_sweep(16'hFF00, 1'b0, 0);
    run_sweep(16'h8888, 1'b0, 0);
    run_sweep(16'hFFFF, 1'b0, 0);
    idle_done(1);

    // abort while index == 5
    run_sweep(16'($urandom), 1'b0, 5 * S + 1);
    @(posedge clk); #1;
    check_zero();
    run_sweep(16'($urandom), 1'b0, 0);

    // start held for the whole sweep must not restart it
    run_sweep(16'($urandom), 1'b1, 0);
    idle_done(3);

    // rst and start together: rst wins
    start = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rst = 1'b0;
    check_zero();

    for (int k = 0; k < 6; k++) begin
      run_sweep(16'($urandom), 1'($urandom_range(0, 1)), 0);
      idle_done(int'($urandom_range(0, 3)));
    end
    run_sweep(16'hFF01, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
